// File: rtl/sram_word_bridge.sv
// Word-wide CPU memory slave that splits each 32-bit access into two 16-bit
// async SRAM accesses (low half first). Optional byte enables: SRAM_WORD_BRIDGE_BYTE_EN.
module sram_word_bridge #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [29:0] addr,
  input  logic [31:0] wdata,
`ifdef SRAM_WORD_BRIDGE_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  // state     | meaning
  // IDLE      | waiting for re/we
  // RD_LO     | reading halfword 0 (bits 15:0)
  // RD_HI     | reading halfword 1 (bits 31:16)
  // WR_LO_SU  | low half: address/data setup, we_n high
  // WR_LO_P   | low half: we_n pulse
  // WR_LO_H   | low half: hold, we_n high
  // WR_HI_SU  | high half: setup
  // WR_HI_P   | high half: we_n pulse
  // WR_HI_H   | high half: hold
  // DONE      | one-cycle completion pulse
  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI,
    WR_LO_SU, WR_LO_P, WR_LO_H,
    WR_HI_SU, WR_HI_P, WR_HI_H,
    DONE
  } state_t;

  localparam int         WAIT_EFF  = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_EFF - 1);

  state_t      state_q, state_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic        cnt_tc;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] lo_q;
  logic [16:0] addr_sel;
  logic [31:0] wdata_sel;
  logic [3:0]  be_sel;
  logic        lo_en, hi_en;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr[29:17];

  // During IDLE the request inputs feed the outputs directly so the first
  // SRAM cycle already carries the new address on the accept edge.
  assign addr_sel  = (state_q == IDLE) ? addr[16:0] : addr_q;
  assign wdata_sel = (state_q == IDLE) ? wdata : wdata_q;

`ifdef SRAM_WORD_BRIDGE_BYTE_EN
  logic [3:0] be_q;
  assign be_sel = (state_q == IDLE) ? be : be_q;
`else
  assign be_sel = 4'hF;
`endif

  assign lo_en  = |be_sel[1:0];
  assign hi_en  = |be_sel[3:2];
  assign cnt_tc = (cnt_q == 4'd0);

  function automatic logic is_rd(state_t s);
    return (s == RD_LO) || (s == RD_HI);
  endfunction

  function automatic logic is_wr(state_t s);
    return (s == WR_LO_SU) || (s == WR_LO_P) || (s == WR_LO_H) ||
           (s == WR_HI_SU) || (s == WR_HI_P) || (s == WR_HI_H);
  endfunction

  function automatic logic is_hi(state_t s);
    return (s == RD_HI) || (s == WR_HI_SU) || (s == WR_HI_P) || (s == WR_HI_H);
  endfunction

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (we) begin
          if (lo_en)      state_nxt = WR_LO_SU;
          else if (hi_en) state_nxt = WR_HI_SU;
          else            state_nxt = DONE;
        end else if (re) begin
          state_nxt = RD_LO;
        end
      end
      RD_LO:    if (cnt_tc) state_nxt = RD_HI;
      RD_HI:    if (cnt_tc) state_nxt = DONE;
      WR_LO_SU: state_nxt = WR_LO_P;
      WR_LO_P:  if (cnt_tc) state_nxt = WR_LO_H;
      WR_LO_H:  state_nxt = hi_en ? WR_HI_SU : DONE;
      WR_HI_SU: state_nxt = WR_HI_P;
      WR_HI_P:  if (cnt_tc) state_nxt = WR_HI_H;
      WR_HI_H:  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (state_nxt != state_q) cnt_nxt = WAIT_LOAD;
    else if (cnt_tc)          cnt_nxt = cnt_q;
    else                      cnt_nxt = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rdata       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
`ifdef SRAM_WORD_BRIDGE_BYTE_EN
      be_q        <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;

      if (state_q == IDLE) begin
        addr_q  <= addr[16:0];
        wdata_q <= wdata;
`ifdef SRAM_WORD_BRIDGE_BYTE_EN
        be_q    <= be;
`endif
      end

      if (state_q == RD_LO && cnt_tc) lo_q  <= sram_dq_in;
      if (state_q == RD_HI && cnt_tc) rdata <= {sram_dq_in, lo_q};

      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
      sram_ce_n  <= !(is_rd(state_nxt) || is_wr(state_nxt));
      sram_oe_n  <= !is_rd(state_nxt);
      sram_we_n  <= !((state_nxt == WR_LO_P) || (state_nxt == WR_HI_P));
      sram_dq_oe <= is_wr(state_nxt);

      if (is_rd(state_nxt) || is_wr(state_nxt))
        sram_addr <= {addr_sel, is_hi(state_nxt)};

      if (is_wr(state_nxt))
        sram_dq_out <= is_hi(state_nxt) ? wdata_sel[31:16] : wdata_sel[15:0];

      // Without byte enables be_sel is all ones, so both lanes stay enabled.
      if (is_rd(state_nxt)) begin
        sram_ub_n <= 1'b0;
        sram_lb_n <= 1'b0;
      end else if (is_wr(state_nxt)) begin
        sram_ub_n <= is_hi(state_nxt) ? ~be_sel[3] : ~be_sel[1];
        sram_lb_n <= is_hi(state_nxt) ? ~be_sel[2] : ~be_sel[0];
      end else begin
        sram_ub_n <= 1'b1;
        sram_lb_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_word_bridge.sv
// Directed testbench for sram_word_bridge with a behavioural async SRAM model.
// Byte-enable scenarios build only when SRAM_WORD_BRIDGE_BYTE_EN is defined.
module tb_sram_word_bridge;

  logic        clk;
  logic        rst;
  logic        re;
  logic        we;
  logic [29:0] addr;
  logic [31:0] wdata;
`ifdef SRAM_WORD_BRIDGE_BYTE_EN
  logic [3:0]  be;
`endif
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_in;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:262143];

  sram_word_bridge #(.WAIT_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .re          (re),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
`ifdef SRAM_WORD_BRIDGE_BYTE_EN
    .be          (be),
`endif
    .rdata       (rdata),
    .busy        (busy),
    .done        (done),
    .sram_addr   (sram_addr),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Async SRAM: reads while ce/oe low, writes latch on the rising we_n edge.
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  always @(posedge sram_we_n) begin
    if (sram_ce_n === 1'b0) begin
      if (sram_lb_n === 1'b0) mem[sram_addr][7:0]  = sram_dq_out[7:0];
      if (sram_ub_n === 1'b0) mem[sram_addr][15:8] = sram_dq_out[15:8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    re  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_assert++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_busy_done cyc %0d: got %b want 00", i, {busy, done});
      end
      n_assert++;
      if (rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rdata cyc %0d: got %h want 0", i, rdata);
      end
      n_assert++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 6'b111110) begin
        n_fail++;
        $display("FAIL reset_ctl cyc %0d: got %b want 111110", i,
                 {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe});
      end
    end
    rst = 1'b0;
    re  = 1'b0;
    tick();
  endtask

  task automatic test_read();
    logic [17:0] exp_a;
    mem[18'h00020] = 16'hBEEF;
    mem[18'h00021] = 16'hDEAD;
    addr = 30'h00010;
    re   = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) re = 1'b0;
      if (k <= 4) begin
        exp_a = (k <= 2) ? 18'h00020 : 18'h00021;
        n_assert++;
        if (sram_addr !== exp_a) begin
          n_fail++;
          $display("FAIL read_addr k=%0d: got %h want %h", k, sram_addr, exp_a);
        end
        n_assert++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 6'b001000) begin
          n_fail++;
          $display("FAIL read_ctl k=%0d: got %b want 001000", k,
                   {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe});
        end
      end
      n_assert++;
      if ({busy, done} !== {(k <= 5), (k == 5)}) begin
        n_fail++;
        $display("FAIL read_busy_done k=%0d: got %b want %b", k, {busy, done}, {(k <= 5), (k == 5)});
      end
      if (k == 5) begin
        n_assert++;
        if (sram_ce_n !== 1'b1) begin
          n_fail++;
          $display("FAIL read_done_ce k=5: got %b want 1", sram_ce_n);
        end
      end
    end
    n_assert++;
    if (rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_rdata: got %h want deadbeef", rdata);
    end
  endtask

  task automatic test_write();
    logic [17:0] exp_a;
    logic [15:0] exp_d;
    logic        exp_we_n;
    mem[18'h3FFFE] = 16'h0000;
    mem[18'h3FFFF] = 16'h0000;
    addr  = 30'h1FFFF;
    wdata = 32'h12345678;
    we    = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) we = 1'b0;
      exp_we_n = !(k == 2 || k == 3 || k == 6 || k == 7);
      n_assert++;
      if ({sram_we_n, sram_oe_n, sram_dq_oe, done} !== {exp_we_n, 1'b1, (k <= 8), (k == 9)}) begin
        n_fail++;
        $display("FAIL write_ctl k=%0d: we_n/oe_n/dq_oe/done got %b want %b", k,
                 {sram_we_n, sram_oe_n, sram_dq_oe, done}, {exp_we_n, 1'b1, (k <= 8), (k == 9)});
      end
      if (k <= 8) begin
        exp_a = (k <= 4) ? 18'h3FFFE : 18'h3FFFF;
        exp_d = (k <= 4) ? 16'h5678 : 16'h1234;
        n_assert++;
        if ({sram_addr, sram_dq_out, sram_ce_n} !== {exp_a, exp_d, 1'b0}) begin
          n_fail++;
          $display("FAIL write_bus k=%0d: addr/data/ce_n got %h/%h/%b want %h/%h/0", k,
                   sram_addr, sram_dq_out, sram_ce_n, exp_a, exp_d);
        end
      end
    end
    n_assert++;
    if ({mem[18'h3FFFE], mem[18'h3FFFF]} !== {16'h5678, 16'h1234}) begin
      n_fail++;
      $display("FAIL write_mem: got %h %h want 5678 1234", mem[18'h3FFFE], mem[18'h3FFFF]);
    end
    n_assert++;
    if (rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_keeps_rdata: got %h want deadbeef", rdata);
    end
  endtask

  task automatic test_simultaneous();
    int n_done = 0;
    int n_we_low = 0;
    int n_oe_low = 0;
    mem[18'h00200] = 16'h0000;
    mem[18'h00201] = 16'h0000;
    mem[18'h00400] = 16'h7777;
    mem[18'h00401] = 16'h7777;
    addr  = 30'h00100;
    wdata = 32'hCAFEF00D;
    re    = 1'b1;
    we    = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (done === 1'b1) n_done++;
      if (sram_we_n === 1'b0) n_we_low++;
      if (sram_oe_n === 1'b0) n_oe_low++;
      if (k == 1) begin
        re = 1'b0; we = 1'b0; wdata = 32'h0;
      end
      if (k == 2) begin
        addr = 30'h00200; wdata = 32'h99999999; re = 1'b1; we = 1'b1;
      end
      if (k == 8) begin
        re = 1'b0; we = 1'b0;
      end
    end
    n_assert++;
    if (n_done !== 1) begin
      n_fail++;
      $display("FAIL simul_done_count: got %0d want 1", n_done);
    end
    n_assert++;
    if ({n_we_low, n_oe_low} !== {32'd4, 32'd0}) begin
      n_fail++;
      $display("FAIL simul_strobes: we_n low %0d oe_n low %0d want 4 0", n_we_low, n_oe_low);
    end
    n_assert++;
    if ({mem[18'h00200], mem[18'h00201], mem[18'h00400], mem[18'h00401]} !==
        {16'hF00D, 16'hCAFE, 16'h7777, 16'h7777}) begin
      n_fail++;
      $display("FAIL simul_mem: got %h %h %h %h want f00d cafe 7777 7777",
               mem[18'h00200], mem[18'h00201], mem[18'h00400], mem[18'h00401]);
    end
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    mem[18'h00060] = 16'h1357;
    mem[18'h00061] = 16'h2468;
    addr = 30'h00030;
    re   = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done === 1'b1) n_done++;
      if (k == 7) re = 1'b0;
      if (k == 5 || k == 6 || k == 7 || k == 11) begin
        n_assert++;
        if ({busy, done} !== {(k != 6), (k == 5 || k == 11)}) begin
          n_fail++;
          $display("FAIL b2b_busy_done k=%0d: got %b want %b", k, {busy, done},
                   {(k != 6), (k == 5 || k == 11)});
        end
      end
    end
    n_assert++;
    if (n_done !== 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d want 2", n_done);
    end
    n_assert++;
    if (rdata !== 32'h24681357) begin
      n_fail++;
      $display("FAIL b2b_rdata: got %h want 24681357", rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    int n_done = 0;
    mem[18'h00040] = 16'h1111;
    mem[18'h00041] = 16'h2222;
    addr  = 30'h00020;
    wdata = 32'hAAAA5555;
    we    = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) we = 1'b0;
    end
    n_assert++;
    if ({sram_we_n, sram_addr} !== {1'b0, 18'h00041}) begin
      n_fail++;
      $display("FAIL rstmid_in_hi_p: we_n/addr got %b/%h want 0/00041", sram_we_n, sram_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_assert++;
    if ({sram_we_n, sram_dq_oe, busy, done, sram_ce_n} !== 5'b10001) begin
      n_fail++;
      $display("FAIL rstmid_outputs: we_n/dq_oe/busy/done/ce_n got %b want 10001",
               {sram_we_n, sram_dq_oe, busy, done, sram_ce_n});
    end
    n_assert++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_rdata: got %h want 0", rdata);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_assert++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got %0d want 0", n_done);
    end
    n_assert++;
    if (mem[18'h00040] !== 16'h5555) begin
      n_fail++;
      $display("FAIL rstmid_lo_mem: got %h want 5555", mem[18'h00040]);
    end
    n_assert++;
    if (mem[18'h00041] !== 16'h2222 && mem[18'h00041] !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL rstmid_hi_mem: got %h want 2222 or aaaa", mem[18'h00041]);
    end
  endtask

`ifdef SRAM_WORD_BRIDGE_BYTE_EN
  task automatic test_byte_en();
    mem[18'h000A0] = 16'h0000;
    mem[18'h000A1] = 16'h0000;
    addr  = 30'h00050;
    wdata = 32'hAABBCCDD;
    be    = 4'b0100;
    we    = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        we = 1'b0; be = 4'hF;
      end
      if (k <= 4) begin
        n_assert++;
        if ({sram_addr, sram_dq_out, sram_ub_n, sram_lb_n, sram_we_n} !==
            {18'h000A1, 16'hAABB, 2'b10, !(k == 2 || k == 3)}) begin
          n_fail++;
          $display("FAIL be_bus k=%0d: addr/data/ub_n,lb_n,we_n got %h/%h/%b want 000a1/aabb/10%b",
                   k, sram_addr, sram_dq_out, {sram_ub_n, sram_lb_n, sram_we_n}, !(k == 2 || k == 3));
        end
      end
      n_assert++;
      if (done !== (k == 5)) begin
        n_fail++;
        $display("FAIL be_done k=%0d: got %b want %b", k, done, (k == 5));
      end
    end
    n_assert++;
    if ({mem[18'h000A0], mem[18'h000A1]} !== {16'h0000, 16'h00BB}) begin
      n_fail++;
      $display("FAIL be_mem: got %h %h want 0000 00bb", mem[18'h000A0], mem[18'h000A1]);
    end
    addr = 30'h00060;
    be   = 4'b0000;
    we   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) begin
        we = 1'b0; be = 4'hF;
      end
      n_assert++;
      if ({busy, done, sram_ce_n} !== {(k == 1), (k == 1), 1'b1}) begin
        n_fail++;
        $display("FAIL be_zero k=%0d: busy/done/ce_n got %b want %b", k,
                 {busy, done, sram_ce_n}, {(k == 1), (k == 1), 1'b1});
      end
    end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    re    = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
`ifdef SRAM_WORD_BRIDGE_BYTE_EN
    be    = 4'hF;
`endif
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_write();
`ifdef SRAM_WORD_BRIDGE_BYTE_EN
    test_byte_en();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
